shrink_queue_fifo: RTL and testbench

//  Narrow-to-wide packer plus buffer FIFO. It is the output-side counterpart of expand_queue_fifo.
//  It collects RATIO = OUT_WIDTH/IN_WIDTH narrow words from an operator output stream and packs them LSB-lane-first.

---
 rtl/shrink_queue_fifo.sv | 137 +++++++++++++
 tb/tb_shrink_queue_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shrink_queue_fifo.sv
// Narrow-to-wide packer feeding a SynFIFO and a registered valid/ready wide output link.
// Optional zero-padded flush of a partial pack is enabled by defining SHRINK_FLUSH_EN.
module shrink_queue_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 512,
  parameter int INPUT_PORT   = 0,
  parameter int FIFO_ASIZE   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IN_WIDTH-1:0]     d_a,
  input  logic                    vld_a,
  output logic                    rdy_a,
  output logic [OUT_WIDTH-1:0]    d_b,
  output logic                    vld_b,
  input  logic                    rdy_b,
`ifdef SHRINK_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    is_done_mode_user,
  output logic [PAYLOAD_BITS-1:0] full_cnt,
  output logic [PAYLOAD_BITS-1:0] empty_cnt,
  output logic [PAYLOAD_BITS-1:0] read_cnt,
  output logic                    stall_condition
);

  localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = $clog2(RATIO);
  localparam int DEPTH  = 2 ** FIFO_ASIZE;

  // Handshakes: a word moves on a link on every rising edge where valid and ready are both
  // high; the source holds its data stable while valid is high and ready is low.
  logic [LANE_W-1:0]    lane_cnt;
  logic                 pack_full;
  logic [OUT_WIDTH-1:0] pack_reg;
  logic                 accept;
  logic                 lane_last;
  logic                 do_flush;
  logic                 wr_en;
  logic                 rd_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FIFO_ASIZE:0]  wptr;
  logic [FIFO_ASIZE:0]  rptr;

  (* ram_style = "distributed" *) logic [OUT_WIDTH-1:0] mem [DEPTH];

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[FIFO_ASIZE] != rptr[FIFO_ASIZE]) &&
                      (wptr[FIFO_ASIZE-1:0] == rptr[FIFO_ASIZE-1:0]);

  // A full pack only blocks input when it cannot drain into the FIFO on this edge.
  assign rdy_a     = !(pack_full && fifo_full);
  assign accept    = vld_a && rdy_a;
  assign lane_last = (lane_cnt == LANE_W'(RATIO - 1));
  assign wr_en     = pack_full && !fifo_full;
  assign rd_en     = !fifo_empty && (!vld_b || rdy_b);

`ifdef SHRINK_FLUSH_EN
  assign do_flush = flush && (lane_cnt != '0) && !pack_full;
`else
  assign do_flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt  <= '0;
      pack_full <= 1'b0;
      pack_reg  <= '0;
    end else begin
      // An accepted word wins its lane; a flush zeroes the current and all higher lanes.
      for (int i = 0; i < RATIO; i++) begin
        if (accept && (lane_cnt == LANE_W'(i)))
          pack_reg[i*IN_WIDTH +: IN_WIDTH] <= d_a;
        else if (do_flush && (LANE_W'(i) >= lane_cnt))
          pack_reg[i*IN_WIDTH +: IN_WIDTH] <= '0;
      end
      if (do_flush || (accept && lane_last))
        lane_cnt <= '0;
      else if (accept)
        lane_cnt <= lane_cnt + LANE_W'(1);
      if (do_flush || (accept && lane_last))
        pack_full <= 1'b1;
      else if (wr_en)
        pack_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr[FIFO_ASIZE-1:0]] <= pack_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_b   <= '0;
      vld_b <= 1'b0;
    end else if (rd_en) begin
      d_b   <= mem[rptr[FIFO_ASIZE-1:0]];
      vld_b <= 1'b1;
    end else if (rdy_b) begin
      vld_b <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_cnt  <= '0;
      empty_cnt <= '0;
      read_cnt  <= '0;
    end else if (!is_done_mode_user) begin
      if (fifo_full)      full_cnt  <= full_cnt + 1'b1;
      if (fifo_empty)     empty_cnt <= empty_cnt + 1'b1;
      if (vld_b && rdy_b) read_cnt  <= read_cnt + 1'b1;
    end
  end

  generate
    if (INPUT_PORT == 1) begin : g_stall_in
      assign stall_condition = !is_done_mode_user && rdy_b && !vld_b;
    end else begin : g_stall_out
      assign stall_condition = !is_done_mode_user && vld_a && !rdy_a;
    end
  endgenerate

endmodule

// File: tb/tb_shrink_queue_fifo.sv
// Directed and randomized bench for shrink_queue_fifo; packed words are predicted from the
// accepted narrow stream with a queue model and compared at every output handshake.
module tb_shrink_queue_fifo;
  localparam int IW = 32;
  localparam int OW = 512;
  localparam int R  = OW / IW;
  localparam int PB = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] d_a;
  logic          vld_a;
  logic          rdy_a;
  logic [OW-1:0] d_b;
  logic          vld_b;
  logic          rdy_b;
  logic          flush;
  logic          is_done_mode_user;
  logic [PB-1:0] full_cnt;
  logic [PB-1:0] empty_cnt;
  logic [PB-1:0] read_cnt;
  logic          stall_condition;

  always #5 clk = ~clk;

  shrink_queue_fifo dut (
    .clk               (clk),
    .reset             (reset),
    .d_a               (d_a),
    .vld_a             (vld_a),
    .rdy_a             (rdy_a),
    .d_b               (d_b),
    .vld_b             (vld_b),
    .rdy_b             (rdy_b),
`ifdef SHRINK_FLUSH_EN
    .flush             (flush),
`endif
    .is_done_mode_user (is_done_mode_user),
    .full_cnt          (full_cnt),
    .empty_cnt         (empty_cnt),
    .read_cnt          (read_cnt),
    .stall_condition   (stall_condition)
  );

  int            checks = 0;
  int            failures = 0;
  logic [OW-1:0] exp_q[$];
  logic [IW-1:0] part_q[$];
  int            n_acc = 0;
  int            n_out = 0;
  bit            stab_pending = 1'b0;
  logic [OW-1:0] held;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample both links mid-cycle, update the model, return #1 after the edge.
  task automatic step();
    bit            flush_now;
    logic [OW-1:0] w;
    @(negedge clk);
    flush_now = 1'b0;
    if (reset === 1'b1) begin
      part_q.delete();
      exp_q.delete();
      stab_pending = 1'b0;
      n_out = 0;
    end else begin
      if (stab_pending) begin
        check("hold_vld", vld_b, 1);
        check("hold_data", d_b, held);
      end
      if (vld_b === 1'b1 && rdy_b === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_underflow observed=unexpected_word expected=none");
        end else begin
          check("sb_word", d_b, exp_q.pop_front());
        end
      end
`ifdef SHRINK_FLUSH_EN
      flush_now = (flush === 1'b1) && (part_q.size() != 0);
`endif
      if (vld_a === 1'b1 && rdy_a === 1'b1) begin
        n_acc++;
        part_q.push_back(d_a);
      end
      if (part_q.size() == R || flush_now) begin
        w = '0;
        for (int i = 0; i < part_q.size(); i++) w[i*IW +: IW] = part_q[i];
        exp_q.push_back(w);
        part_q.delete();
      end
      stab_pending = (vld_b === 1'b1) && (rdy_b === 1'b0);
      held = d_b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      vld_a = 1'b1;
      d_a   = $urandom;
      step();
    end
    vld_a = 1'b0;
  endtask

  initial begin
    int guard;
    logic [PB-1:0] f0;
    logic [PB-1:0] e0;
    reset = 1'b1;
    vld_a = 1'b0;
    d_a = '0;
    rdy_b = 1'b0;
    flush = 1'b0;
    is_done_mode_user = 1'b0;
    step();
    step();
    check("rst_vld_b", vld_b, 0);
    check("rst_d_b", d_b, 0);
    check("rst_full_cnt", full_cnt, 0);
    check("rst_empty_cnt", empty_cnt, 0);
    check("rst_read_cnt", read_cnt, 0);
    check("rst_rdy_a", rdy_a, 1);
    reset = 1'b0;
    step();
    check("empty_cnt_first", empty_cnt, 1);

    // T1: packing order and latency.
    rdy_b = 1'b1;
    for (int i = 1; i <= R; i++) begin
      vld_a = 1'b1;
      d_a   = IW'(i);
      step();
    end
    vld_a = 1'b0;
    check("lat_edge0", vld_b, 0);
    step();
    check("lat_edge1", vld_b, 0);
    step();
    check("lat_edge2", vld_b, 1);
    check("t1_lane0", d_b[IW-1:0], 1);
    check("t1_lane15", d_b[OW-1 -: IW], 16);
    step();
    check("t1_one_cycle", vld_b, 0);
    check("t1_read_cnt", read_cnt, 1);

    // T2: backpressure fills FIFO, pack register and output register.
    rdy_b = 1'b0;
    n_acc = 0;
    guard = 0;
    vld_a = 1'b1;
    while (rdy_a === 1'b1 && guard < 2000) begin
      d_a = $urandom;
      step();
      guard++;
    end
    check("t2_accepts", n_acc, 34 * R);
    check("t2_rdy_a_low", rdy_a, 0);
    check("t2_stall", stall_condition, 1);
    f0 = full_cnt;
    step();
    check("t2_full_cnt_inc", full_cnt, f0 + 1'b1);
    check("t2_still_blocked", rdy_a, 0);
    vld_a = 1'b0;
    #1;
    check("t2_stall_clear", stall_condition, 0);
    rdy_b = 1'b1;
    repeat (60) step();
    check("t2_drained", exp_q.size(), 0);
    check("t2_read_cnt", read_cnt, 35);

    // T3: random handshakes on both links.
    for (int c = 0; c < 10000; c++) begin
      vld_a = 1'($urandom_range(0, 1));
      d_a   = $urandom;
      rdy_b = ($urandom_range(0, 3) != 0);
      step();
    end
    vld_a = 1'b0;
    rdy_b = 1'b1;
    repeat (60) step();
    check("t3_drained", exp_q.size(), 0);
    check("t3_read_cnt", read_cnt, n_out);

    // T4: profiling freeze with the FIFO empty.
    is_done_mode_user = 1'b1;
    e0 = empty_cnt;
    repeat (100) step();
    check("t4_frozen", empty_cnt, e0);
    is_done_mode_user = 1'b0;
    repeat (10) step();
    check("t4_resumed", empty_cnt, e0 + 10);

    // T5: reset in the middle of a pack.
    push_words(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_read_cnt", read_cnt, 0);
    check("t5_rst_empty_cnt", empty_cnt, 0);
    check("t5_rst_vld_b", vld_b, 0);
    push_words(R);
    repeat (10) step();
    check("t5_drained", exp_q.size(), 0);
    check("t5_read_cnt", read_cnt, 1);

`ifdef SHRINK_FLUSH_EN
    // T6: flush pads a partial pack with zeros.
    push_words(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (10) step();
    check("t6_flush_out", read_cnt, 2);
    check("t6_drained", exp_q.size(), 0);
    push_words(R);
    repeat (10) step();
    check("t6_fresh_read_cnt", read_cnt, 3);
    check("t6_fresh_drained", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
